// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: video timing bus, ce/restart control in, counters and sync/blank flags out
interface vga_timing_gen_if #(parameter int CNT_W = 11);
  logic ce;
  logic restart;
  logic [CNT_W-1:0] hcount;
  logic [CNT_W-1:0] vcount;
  logic hsync;
  logic vsync;
  logic hblnk;
  logic vblnk;
  logic de;
  logic line_start;
  logic frame_start;
  modport master (
    input  ce, restart,
    output hcount, vcount, hsync, vsync, hblnk, vblnk, de, line_start, frame_start
  );
  modport slave (
    output ce, restart,
    input  hcount, vcount, hsync, vsync, hblnk, vblnk, de, line_start, frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parameterised VGA raster timing generator with registered, count-aligned flags
// Ports: clk pixel clock; rst_n sync active-low reset; bus.master carries ce/restart in and
// hcount/vcount/hsync/vsync/hblnk/vblnk/de/line_start/frame_start out.
module vga_timing_gen #(
  parameter int CNT_W     = 11,
  parameter int H_ACTIVE  = 800,
  parameter int H_FP      = 40,
  parameter int H_SYNC    = 128,
  parameter int H_BP      = 88,
  parameter int V_ACTIVE  = 600,
  parameter int V_FP      = 1,
  parameter int V_SYNC    = 4,
  parameter int V_BP      = 23,
  parameter bit HSYNC_POL = 1'b1,
  parameter bit VSYNC_POL = 1'b1
) (
  input logic clk,
  input logic rst_n,
  vga_timing_gen_if.master bus
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int W = CNT_W + 1;
  localparam logic [CNT_W:0] HT1 = W'(H_TOTAL - 1);
  localparam logic [CNT_W:0] VT1 = W'(V_TOTAL - 1);
  localparam logic [CNT_W:0] HA  = W'(H_ACTIVE);
  localparam logic [CNT_W:0] VA  = W'(V_ACTIVE);
  localparam logic [CNT_W:0] HS0 = W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W:0] HS1 = W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W:0] VS0 = W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W:0] VS1 = W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CNT_W:0] ONE = W'(1);
  if (H_TOTAL > 2**CNT_W || V_TOTAL > 2**CNT_W || H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 ||
      H_BP == 0 || V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_params
    $error("vga_timing_gen: invalid timing parameters");
  end
  logic [CNT_W:0] h_cur, v_cur, h_nx, v_nx;
  logic h_last, v_last, wrap_line;
  // Counters are widened by one bit so a total of exactly 2^CNT_W compares cleanly.
  always_comb begin
    h_cur = {1'b0, bus.hcount};
    v_cur = {1'b0, bus.vcount};
    h_last = h_cur == HT1;
    v_last = v_cur == VT1;
    wrap_line = bus.ce && h_last;
    h_nx = bus.restart ? '0 : !bus.ce ? h_cur : h_last ? '0 : h_cur + ONE;
    v_nx = bus.restart ? '0 : !wrap_line ? v_cur : v_last ? '0 : v_cur + ONE;
  end
  // Flags are derived from the next count so they land in the same cycle as the count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.hcount <= '0;
      bus.vcount <= '0;
      bus.hblnk <= 1'b0;
      bus.vblnk <= 1'b0;
      bus.de <= 1'b1;
      bus.hsync <= !HSYNC_POL;
      bus.vsync <= !VSYNC_POL;
      bus.line_start <= 1'b0;
      bus.frame_start <= 1'b0;
    end else begin
      bus.hcount <= h_nx[CNT_W-1:0];
      bus.vcount <= v_nx[CNT_W-1:0];
      bus.hblnk <= h_nx >= HA;
      bus.vblnk <= v_nx >= VA;
      bus.de <= h_nx < HA && v_nx < VA;
      bus.hsync <= (h_nx >= HS0 && h_nx < HS1) ? HSYNC_POL : !HSYNC_POL;
      bus.vsync <= (v_nx >= VS0 && v_nx < VS1) ? VSYNC_POL : !VSYNC_POL;
      bus.line_start <= bus.restart || wrap_line;
      bus.frame_start <= bus.restart || (wrap_line && v_last);
    end
  end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed vector table plus sweeps over default, tiny and 640x480 timings
module tb_vga_timing_gen;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ce = 1'b0;
  logic restart = 1'b0;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  vga_timing_gen_if #(.CNT_W(11)) bus_a();
  vga_timing_gen_if #(.CNT_W(4))  bus_b();
  vga_timing_gen_if #(.CNT_W(10)) bus_c();
  assign bus_a.ce = ce;
  assign bus_a.restart = restart;
  assign bus_b.ce = ce;
  assign bus_b.restart = restart;
  assign bus_c.ce = ce;
  assign bus_c.restart = restart;
  vga_timing_gen dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  // Tiny raster: H_TOTAL = 16 = 2^CNT_W, V_TOTAL = 8, active-low syncs, frame = 128 cycles.
  vga_timing_gen #(
    .CNT_W(4), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
  ) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));
  vga_timing_gen #(
    .CNT_W(10), .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
    .V_ACTIVE(480), .V_FP(10), .V_SYNC(2), .V_BP(33), .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
  ) dut_c (.clk(clk), .rst_n(rst_n), .bus(bus_c));
  typedef struct {
    logic ce, rs, rn;
    int h, v;
    logic hs, hb, vb, de, ls, fs;
  } vec_t;
  vec_t tbl[7];
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic step(input logic c, input logic r, input logic n);
    ce = c;
    restart = r;
    rst_n = n;
    @(posedge clk);
    #1;
  endtask
  task automatic chk_b_reset(input string tag);
    chk({tag, ".b.h"}, int'(bus_b.hcount), 0);
    chk({tag, ".b.v"}, int'(bus_b.vcount), 0);
    chk({tag, ".b.hb"}, int'(bus_b.hblnk), 0);
    chk({tag, ".b.vb"}, int'(bus_b.vblnk), 0);
    chk({tag, ".b.de"}, int'(bus_b.de), 1);
    chk({tag, ".b.hs"}, int'(bus_b.hsync), 1);
    chk({tag, ".b.vs"}, int'(bus_b.vsync), 1);
    chk({tag, ".b.ls"}, int'(bus_b.line_start), 0);
    chk({tag, ".b.fs"}, int'(bus_b.frame_start), 0);
  endtask
  initial begin
    //           ce rs rn  h  v  hs hb vb de ls fs
    tbl[0] = '{1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0};
    tbl[1] = '{1, 0, 1, 1, 0, 0, 0, 0, 1, 0, 0};
    tbl[2] = '{1, 0, 1, 2, 0, 0, 0, 0, 1, 0, 0};
    tbl[3] = '{0, 0, 1, 2, 0, 0, 0, 0, 1, 0, 0};
    tbl[4] = '{0, 1, 1, 0, 0, 0, 0, 0, 1, 1, 1};
    tbl[5] = '{1, 0, 1, 1, 0, 0, 0, 0, 1, 0, 0};
    tbl[6] = '{1, 0, 1, 2, 0, 0, 0, 0, 1, 0, 0};
    for (int i = 0; i < 7; i++) begin
      step(tbl[i].ce, tbl[i].rs, tbl[i].rn);
      chk($sformatf("vec%0d.h", i), int'(bus_a.hcount), tbl[i].h);
      chk($sformatf("vec%0d.v", i), int'(bus_a.vcount), tbl[i].v);
      chk($sformatf("vec%0d.hs", i), int'(bus_a.hsync), int'(tbl[i].hs));
      chk($sformatf("vec%0d.hb", i), int'(bus_a.hblnk), int'(tbl[i].hb));
      chk($sformatf("vec%0d.vb", i), int'(bus_a.vblnk), int'(tbl[i].vb));
      chk($sformatf("vec%0d.de", i), int'(bus_a.de), int'(tbl[i].de));
      chk($sformatf("vec%0d.ls", i), int'(bus_a.line_start), int'(tbl[i].ls));
      chk($sformatf("vec%0d.fs", i), int'(bus_a.frame_start), int'(tbl[i].fs));
    end
    // ce pattern 1,0,0,1 starting at hcount 10
    for (int i = 0; i < 8; i++) step(1, 0, 1);
    chk("ce.start", int'(bus_a.hcount), 10);
    begin
      logic ce_seq[4];
      int h_seq[4];
      ce_seq = '{1, 0, 0, 1};
      h_seq = '{11, 11, 11, 12};
      for (int i = 0; i < 4; i++) begin
        step(ce_seq[i], 0, 1);
        chk($sformatf("ce%0d.h", i), int'(bus_a.hcount), h_seq[i]);
        chk($sformatf("ce%0d.ls", i), int'(bus_a.line_start), 0);
        chk($sformatf("ce%0d.fs", i), int'(bus_a.frame_start), 0);
      end
    end
    // Restart with ce=1 then sweep past one full default line.
    step(1, 1, 1);
    chk("rs.a.fs", int'(bus_a.frame_start), 1);
    chk("rs.b.fs", int'(bus_b.frame_start), 1);
    chk("rs.c.fs", int'(bus_c.frame_start), 1);
    for (int k = 1; k <= 1060; k++) begin
      int ha, va, hb, vb, hc;
      step(1, 0, 1);
      ha = k % 1056;
      va = k / 1056;
      hb = k % 16;
      vb = (k / 16) % 8;
      hc = k % 800;
      chk($sformatf("sw%0d.a.h", k), int'(bus_a.hcount), ha);
      chk($sformatf("sw%0d.a.v", k), int'(bus_a.vcount), va);
      chk($sformatf("sw%0d.a.hs", k), int'(bus_a.hsync), int'(ha >= 840 && ha <= 967));
      chk($sformatf("sw%0d.a.hb", k), int'(bus_a.hblnk), int'(ha >= 800));
      chk($sformatf("sw%0d.a.de", k), int'(bus_a.de), int'(ha < 800));
      chk($sformatf("sw%0d.a.ls", k), int'(bus_a.line_start), int'(ha == 0));
      chk($sformatf("sw%0d.a.fs", k), int'(bus_a.frame_start), 0);
      chk($sformatf("sw%0d.b.h", k), int'(bus_b.hcount), hb);
      chk($sformatf("sw%0d.b.v", k), int'(bus_b.vcount), vb);
      chk($sformatf("sw%0d.b.hs", k), int'(bus_b.hsync), int'(!(hb >= 10 && hb <= 12)));
      chk($sformatf("sw%0d.b.vs", k), int'(bus_b.vsync), int'(!(vb >= 5 && vb <= 6)));
      chk($sformatf("sw%0d.b.hb", k), int'(bus_b.hblnk), int'(hb >= 8));
      chk($sformatf("sw%0d.b.vb", k), int'(bus_b.vblnk), int'(vb >= 4));
      chk($sformatf("sw%0d.b.de", k), int'(bus_b.de), int'(hb < 8 && vb < 4));
      chk($sformatf("sw%0d.b.ls", k), int'(bus_b.line_start), int'(hb == 0));
      chk($sformatf("sw%0d.b.fs", k), int'(bus_b.frame_start), int'(k % 128 == 0));
      chk($sformatf("sw%0d.c.h", k), int'(bus_c.hcount), hc);
      chk($sformatf("sw%0d.c.hs", k), int'(bus_c.hsync), int'(!(hc >= 656 && hc <= 751)));
      chk($sformatf("sw%0d.c.ls", k), int'(bus_c.line_start), int'(hc == 0));
    end
    // Restart mid-frame with ce=0: A at (4,1), B at (4,2).
    step(0, 1, 1);
    chk("rsm.a.h", int'(bus_a.hcount), 0);
    chk("rsm.a.v", int'(bus_a.vcount), 0);
    chk("rsm.a.fs", int'(bus_a.frame_start), 1);
    chk("rsm.a.ls", int'(bus_a.line_start), 1);
    chk("rsm.a.de", int'(bus_a.de), 1);
    chk("rsm.b.v", int'(bus_b.vcount), 0);
    chk("rsm.b.fs", int'(bus_b.frame_start), 1);
    step(0, 0, 1);
    chk("hold.a.h", int'(bus_a.hcount), 0);
    chk("hold.a.ls", int'(bus_a.line_start), 0);
    chk("hold.a.fs", int'(bus_a.frame_start), 0);
    chk("hold.a.de", int'(bus_a.de), 1);
    // Reset on the last pixel of B's frame must suppress the wrap pulse.
    for (int i = 0; i < 127; i++) step(1, 0, 1);
    chk("pre.b.h", int'(bus_b.hcount), 15);
    chk("pre.b.v", int'(bus_b.vcount), 7);
    chk("pre.a.h", int'(bus_a.hcount), 127);
    step(1, 0, 0);
    chk_b_reset("rst");
    chk("rst.a.h", int'(bus_a.hcount), 0);
    chk("rst.a.hs", int'(bus_a.hsync), 0);
    step(1, 0, 1);
    chk("post.a.h", int'(bus_a.hcount), 1);
    chk("post.b.h", int'(bus_b.hcount), 1);
    chk("post.b.v", int'(bus_b.vcount), 0);
    chk("post.b.fs", int'(bus_b.frame_start), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
